// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller.
package sar_pkg;
  localparam int SAR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } sar_state_t;
endpackage

// File: rtl/sar_search_if.sv
// Controller <-> requester/comparator bundle; slave is the controller side.
interface sar_search_if #(parameter int WIDTH = 4);
  logic             start;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             cmp_lt;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (output start, cmp_eq, cmp_gt, cmp_lt,
                  input  trial, busy, done, err, result);
  modport slave  (input  start, cmp_eq, cmp_gt, cmp_lt,
                  output trial, busy, done, err, result);
endinterface

// File: rtl/sar_search.sv
// MSB-first binary search driving an external magnitude comparator.
// One trial bit is resolved per clock; eq exits early, bad flags abort with err.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input logic         clk,
  input logic         rst,
  sar_search_if.slave bus
);
  localparam int IW = $clog2(WIDTH);

  sar_state_t       state;
  logic [WIDTH-1:0] trial, result, bit_m, nxt_trial;
  logic [IW-1:0]    bit_idx;
  logic             err, one_hot;

  // Resolve bit k and arm bit k-1 with masks only; no adders on the trial path.
  always_comb begin
    bit_m     = WIDTH'(1) << bit_idx;
    nxt_trial = (bus.cmp_gt ? (trial & ~bit_m) : trial) | (bit_m >> 1);
    one_hot   = (bus.cmp_eq ^ bus.cmp_gt ^ bus.cmp_lt) &
                ~(bus.cmp_eq & bus.cmp_gt & bus.cmp_lt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      trial   <= '0;
      result  <= '0;
      bit_idx <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            trial   <= {1'b1, {(WIDTH-1){1'b0}}};
            bit_idx <= IW'(WIDTH-1);
            err     <= 1'b0;
            state   <= SEARCH;
          end else begin
            state   <= IDLE;
          end
        end
        SEARCH: begin
          if (!one_hot) begin
            result <= trial;
            err    <= 1'b1;
            state  <= DONE;
          end else if (bus.cmp_eq) begin
            result <= trial;
            state  <= DONE;
          end else if (bit_idx != '0) begin
            trial   <= nxt_trial;
            bit_idx <= bit_idx - IW'(1);
          end else if (bus.cmp_gt) begin
            trial  <= {trial[WIDTH-1:1], 1'b0};
            result <= {trial[WIDTH-1:1], 1'b0};
            state  <= DONE;
          end else begin
            result <= trial;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.trial  = trial;
  assign bus.result = result;
  assign bus.err    = err;
  assign bus.busy   = (state == SEARCH);
  assign bus.done   = (state == DONE);
endmodule
